// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM slave for the mem-stage data port.
// Optional range checking with err output: define DMEM_ERR_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [3:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready
`ifdef DMEM_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int         DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]            cnt;
    logic [3:0]            cnt_next;
    logic                  take;
    logic                  commit;

    logic [ADDR_WIDTH-1:0] idx_q;
    logic [3:0]            we_q;
    logic [31:0]           wdata_q;
    logic                  oor_q;

    logic [ADDR_WIDTH-1:0] idx_in;
    logic                  oor_in;
    logic [ADDR_WIDTH-1:0] eff_idx;
    logic [3:0]            eff_we;
    logic [31:0]           eff_wdata;
    logic                  eff_oor;

    logic [31:0]           mem [DEPTH];

    logic                  unused;

    assign idx_in = addr[ADDR_WIDTH+1:2];

`ifdef DMEM_ERR_EN
    assign oor_in = |addr[31:ADDR_WIDTH+2];
`else
    assign oor_in = 1'b0;
`endif

    // Lane selection comes from we; upper bits alias unless range-checked.
    assign unused = ^{addr[1:0], addr[31:ADDR_WIDTH+2]};

    // Outside WAIT a commit can only come from a zero-wait request,
    // so the live request fields are used; in WAIT the captured ones.
    assign eff_idx   = (state == WAIT) ? idx_q   : idx_in;
    assign eff_we    = (state == WAIT) ? we_q    : we;
    assign eff_wdata = (state == WAIT) ? wdata_q : wdata;
    assign eff_oor   = (state == WAIT) ? oor_q   : oor_in;

    assign ready = (state == RESP);

    // Next-state, counter and commit decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        take       = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE, RESP: begin
                if (req) begin
                    take       = 1'b1;
                    cnt_next   = WAIT_LD;
                    if (WAIT_LD != 4'd0) begin
                        state_next = WAIT;
                    end else begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    cnt_next   = 4'd0;
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // State, counter, request capture and read-first response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata   <= 32'h0;
            idx_q   <= '0;
            we_q    <= 4'b0000;
            wdata_q <= 32'h0;
            oor_q   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (take) begin
                idx_q   <= idx_in;
                we_q    <= we;
                wdata_q <= wdata;
                oor_q   <= oor_in;
            end
            if (commit) begin
                rdata <= eff_oor ? 32'h0 : mem[eff_idx];
            end
        end
    end

`ifdef DMEM_ERR_EN
    // Range error pulse aligned with the ready cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= commit & eff_oor;
        end
    end
`endif

    // Byte-lane RAM write; a commit blocked by reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && commit && !eff_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_we[i]) begin
                    mem[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait
// states, one with zero wait states sharing clock and reset.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        req2;
    logic [3:0]  we2;
    logic [31:0] addr2;
    logic [31:0] wdata2;
    logic [31:0] rdata2;
    logic        ready2;

    logic        req0;
    logic [3:0]  we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic [31:0] rdata0;
    logic        ready0;

`ifdef DMEM_ERR_EN
    logic        err2;
    logic        err0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .req   (req2),
        .we    (we2),
        .addr  (addr2),
        .wdata (wdata2),
        .rdata (rdata2),
        .ready (ready2)
`ifdef DMEM_ERR_EN
        ,
        .err   (err2)
`endif
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .req   (req0),
        .we    (we0),
        .addr  (addr0),
        .wdata (wdata0),
        .rdata (rdata0),
        .ready (ready0)
`ifdef DMEM_ERR_EN
        ,
        .err   (err0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access on the two-wait-state instance, issued in cycle 0.
    task automatic acc2(input string tag, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, output logic [31:0] r);
        int n;
        req2   = 1'b1;
        we2    = w;
        addr2  = a;
        wdata2 = d;
        step();
        req2 = 1'b0;
        we2  = 4'b0000;
        n    = 1;
        while (!ready2 && n < 20) begin
            step();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd3);
        check({tag, " ready"}, 32'(ready2), 32'd1);
`ifdef DMEM_ERR_EN
        check({tag, " err"}, 32'(err2), 32'(exp_err));
`else
        if (exp_err) $display("note: %s expects err only with range check", tag);
`endif
        r = rdata2;
        step();
        check({tag, " pulse"}, 32'(ready2), 32'd0);
        check({tag, " hold"}, rdata2, r);
    endtask

    initial begin
        rst    = 1'b1;
        req2   = 1'b0;
        we2    = 4'b0000;
        addr2  = 32'h0;
        wdata2 = 32'h0;
        req0   = 1'b0;
        we0    = 4'b0000;
        addr0  = 32'h0;
        wdata0 = 32'h0;
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            check("idle ready2", 32'(ready2), 32'd0);
            check("idle rdata2", rdata2, 32'h0);
            check("idle ready0", 32'(ready0), 32'd0);
            check("idle rdata0", rdata0, 32'h0);
        end

        acc2("wr full", 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, rd);
        acc2("rd full", 4'b0000, 32'h10, 32'h0, 1'b0, rd);
        check("rd full data", rd, 32'hDEADBEEF);

        acc2("sb", 4'b0100, 32'h11, 32'h55555555, 1'b0, rd);
        check("sb old data", rd, 32'hDEADBEEF);
        acc2("rd sb", 4'b0000, 32'h10, 32'h0, 1'b0, rd);
        check("rd sb data", rd, 32'hDE55BEEF);

        acc2("sh", 4'b0011, 32'h12, 32'h12341234, 1'b0, rd);
        check("sh old data", rd, 32'hDE55BEEF);
        acc2("rd sh", 4'b0000, 32'h10, 32'h0, 1'b0, rd);
        check("rd sh data", rd, 32'hDE551234);

        acc2("wr 30 pre", 4'b1111, 32'h30, 32'h0, 1'b0, rd);
        req2   = 1'b1;
        we2    = 4'b1111;
        addr2  = 32'h30;
        wdata2 = 32'h11111111;
        step();
        req2 = 1'b0;
        we2  = 4'b0000;
        check("rst c1 ready", 32'(ready2), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst c2 ready", 32'(ready2), 32'd0);
        check("rst rdata", rdata2, 32'h0);
        step();
        check("rst c3 ready", 32'(ready2), 32'd0);
        step();
        check("rst c4 ready", 32'(ready2), 32'd0);
        acc2("rd 30", 4'b0000, 32'h30, 32'h0, 1'b0, rd);
        check("rd 30 data", rd, 32'h0);

        req0   = 1'b1;
        we0    = 4'b1111;
        addr0  = 32'h20;
        wdata0 = 32'h0;
        step();
        req0 = 1'b0;
        check("d0 pre ready", 32'(ready0), 32'd1);
        step();
        check("d0 pre pulse", 32'(ready0), 32'd0);
        req0   = 1'b1;
        we0    = 4'b1111;
        addr0  = 32'h20;
        wdata0 = 32'hAAAAAAAA;
        step();
        check("b2b wr ready", 32'(ready0), 32'd1);
        check("b2b wr rdata", rdata0, 32'h0);
        we0    = 4'b0000;
        wdata0 = 32'h0;
        step();
        check("b2b rd ready", 32'(ready0), 32'd1);
        check("b2b rd rdata", rdata0, 32'hAAAAAAAA);
        req0 = 1'b0;
        step();
        check("b2b end ready", 32'(ready0), 32'd0);
        check("b2b end rdata", rdata0, 32'hAAAAAAAA);

        acc2("wr w0", 4'b1111, 32'h0, 32'h01020304, 1'b0, rd);
`ifdef DMEM_ERR_EN
        acc2("wr oor", 4'b1111, 32'h1000, 32'hCAFEF00D, 1'b1, rd);
        check("oor rdata", rd, 32'h0);
        acc2("rd w0", 4'b0000, 32'h0, 32'h0, 1'b0, rd);
        check("rd w0 data", rd, 32'h01020304);
`else
        acc2("wr alias", 4'b1111, 32'h1000, 32'hCAFEF00D, 1'b0, rd);
        check("alias old", rd, 32'h01020304);
        acc2("rd w0", 4'b0000, 32'h0, 32'h0, 1'b0, rd);
        check("rd w0 data", rd, 32'hCAFEF00D);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core: the slave end of the core's mem-stage data port. It accepts word-aligned requests carrying 4-bit byte-lane write enables, an address and lane-replicated write data, and stores into an internal word RAM using big-endian lane mapping. It returns read words after a configurable number of wait states. A one-cycle `ready` pulse tells the core's hazard logic when to release its stall.

## Interface
- `ADDR_WIDTH`, default 10: word-index bits; RAM holds 2^ADDR_WIDTH 32-bit words (default 4 KiB).
- `WAIT_CYCLES`, default 2: wait states per access; legal range 0..15.

Ports:
- `clk`  in  1: sole clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  1: access request from mem stage.
- `we`  in  4: byte-lane write enables; `we[3]` = bits 31:24 = byte offset 0 (big-endian). `4'b0000` = read.
- `addr`  in  32: byte address; word index is `addr[ADDR_WIDTH+1:2]`; `addr[1:0]` ignored (lanes come from `we`).
- `wdata`  in  32: write data, already lane-replicated by the core.
- `rdata`  out  32: full read word, registered; core extracts bytes and halfwords.
- `ready`  out  1: one-cycle response pulse.
- `err`  out  1: out-of-range pulse; present only with `DMEM_ERR_EN`.

## Operation
- FSM states:
  - IDLE: if `req`=1, capture `addr`, `we`, `wdata` and load the wait counter with `WAIT_CYCLES`. Next state is WAIT if `WAIT_CYCLES`>0, else RESP.
  - WAIT: counter decrements each cycle; on reaching 0, go to RESP.
  - RESP: the transition into RESP commits the write and updates `rdata`. `ready`=1 for exactly this cycle.
    - `req`=1 in RESP: the new request is captured, exactly as in IDLE (back-to-back).
    - `req`=0 in RESP: return to IDLE.
- Request sampling: `req` and its fields are sampled only in IDLE or RESP. Changes during WAIT are ignored. The core holds its stall until `ready`.
- Write: each set `we[i]` replaces byte lane i (bits 8i+7:8i) of the addressed word; unset lanes are unchanged.
- Read-first: `rdata` receives the word's contents from before the write, on both reads and writes.
- `rdata` holds its value between responses; it changes only on entry to RESP.
- `we`=`4'b1111` with any `addr[1:0]` writes the full word.
- RAM contents are not cleared by reset and are undefined until written.

## Timing
- Reset values: state IDLE, counter 0, `ready`=0, `rdata`=32'h0, `err`=0.
- Latency: `req` high in cycle 0 (accepted at the end of cycle 0) gives `ready` high in cycle `WAIT_CYCLES`+1; `rdata` is valid in that same cycle.
- Throughput:
  - back-to-back requests complete one per `WAIT_CYCLES`+1 cycles;
  - with `WAIT_CYCLES`=0, a request held high gives `ready` every cycle.
- Reset mid-operation: a pending captured write is dropped with no RAM update. `ready` does not pulse.
- Only RAM state persists across reset.

## Configuration
- `DMEM_ERR_EN` defined:
  - an access is out of range when `addr[31:ADDR_WIDTH+2]` is nonzero;
  - out-of-range writes are suppressed, and `rdata` = 32'h0 on the response;
  - `err` pulses in the same cycle as `ready`; `ready` and latency are otherwise unchanged.
- `DMEM_ERR_EN` undefined: no `err` port; upper address bits are ignored, so accesses alias modulo RAM size.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, then `req`=0 for 5 cycles -> `ready`=0 and `rdata`=0 throughout.
- Full-word write, then read, `WAIT_CYCLES`=2:
  - write `addr`=0x10, `we`=4'b1111, `wdata`=0xDEADBEEF -> `ready` in cycle 3;
  - then read `addr`=0x10 -> `rdata`=0xDEADBEEF with `ready`.
- Byte lanes, starting from word 0x10 = 0xDEADBEEF:
  - sb-style write `addr`=0x11, `we`=4'b0100, `wdata`=0x55555555;
  - read -> 0xDE55BEEF.
  - sh-style write `we`=4'b0011, `wdata`=0x12341234, then read -> 0xDE551234.
- Read-first and back-to-back, `WAIT_CYCLES`=0:
  - `req` held high: write 0xAAAAAAAA to 0x20 (old 0x0), then read 0x20;
  - -> `rdata`=0x0 then 0xAAAAAAAA on consecutive `ready` cycles.
- Reset mid-access: issue write 0x11111111 to 0x30 (old 0x0), assert `rst` in cycle 1 (during WAIT), then read 0x30 -> 0x0; no `ready` before the reset.
- `DMEM_ERR_EN` on, `ADDR_WIDTH`=10: write to 0x00001000 -> `err`=1 and `ready`=1 in the same cycle, `rdata`=0. Word 0x0 is unchanged on read-back. With the macro off, the same write aliases to word 0.
